// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the MixColumns datapath.
package aes128_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] state128_t;
    typedef logic [31:0]  col32_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_t;

    // Multiply by x in GF(2^8) reduced by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_mix_column.sv
// Single-column (Inv)MixColumns, purely combinational; all products built from xtime chains.
module aes128_mix_column
    import aes128_pkg::*;
(
    input  col32_t colIn,
    input  logic   inv,
    output col32_t colOut
);

    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];

    for (genvar r = 0; r < 4; r++) begin : gByte
        assign a[r]  = colIn[r*8 +: 8];
        assign m2[r] = xtime(a[r]);
        assign m4[r] = xtime(m2[r]);
        assign m8[r] = xtime(m4[r]);
    end

    // Row r uses byte r with the leading coefficient, then rotates through r+1..r+3.
    for (genvar r = 0; r < 4; r++) begin : gRow
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;

        logic [7:0] fwdByte;
        logic [7:0] invByte;

        assign fwdByte = m2[r] ^ (m2[R1] ^ a[R1]) ^ a[R2] ^ a[R3];
        assign invByte = (m8[r] ^ m4[r] ^ m2[r])
                       ^ (m8[R1] ^ m2[R1] ^ a[R1])
                       ^ (m8[R2] ^ m4[R2] ^ a[R2])
                       ^ (m8[R3] ^ a[R3]);

        assign colOut[r*8 +: 8] = inv ? invByte : fwdByte;
    end

endmodule

// File: rtl/aes128_mix_columns.sv
// Iterative AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns per BUSY cycle,
// with valid/ready handshakes on both sides and a bypass path for the final round.
module aes128_mix_columns
    import aes128_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    input  logic         inv_i,
    input  logic         bypass_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadParam
        $error("aes128_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // For 4 columns per cycle the step wraps to 0, which is harmless: BUSY lasts one cycle.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    mc_state_t state;
    mc_state_t nextState;
    logic [1:0] colCnt;
    state128_t  workReg;
    state128_t  workNext;
    logic       invFlag;
    logic       bypassFlag;
    logic       accept;

    col32_t     colIn  [COLS_PER_CYCLE];
    col32_t     colOut [COLS_PER_CYCLE];
    logic [1:0] colIdx [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : gCol
        assign colIdx[i] = colCnt + 2'(i);
        assign colIn[i]  = workReg[{colIdx[i], 5'b0} +: 32];

        aes128_mix_column uMixColumn (
            .colIn  (colIn[i]),
            .inv    (invFlag),
            .colOut (colOut[i])
        );
    end

    always_comb begin
        workNext = workReg;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            workNext[{colIdx[i], 5'b0} +: 32] = colOut[i];
        end
    end

    assign accept = in_valid_i && (state == IDLE);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (in_valid_i) nextState = bypass_i ? DONE : BUSY;
            BUSY: if (colCnt == LAST_COL || bypassFlag) nextState = DONE;
            DONE: if (out_ready_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            workReg    <= '0;
            colCnt     <= '0;
            invFlag    <= 1'b0;
            bypassFlag <= 1'b0;
        end else if (accept) begin
            workReg    <= data_i;
            colCnt     <= '0;
            invFlag    <= inv_i;
            bypassFlag <= bypass_i;
        end else if (state == BUSY && !bypassFlag) begin
            workReg <= workNext;
            colCnt  <= colCnt + CNT_STEP;
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign data_o      = workReg;

endmodule

// File: tb/tb_aes128_mix_columns.sv
// Self-checking bench: three instances (1, 2, 4 columns per cycle) against a GF(2^8) matrix model.
module tb_aes128_mix_columns;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid  [3];
    logic         inReady  [3];
    logic [127:0] dataIn   [3];
    logic         invIn    [3];
    logic         bypassIn [3];
    logic         outValid [3];
    logic         outReady [3];
    logic [127:0] dataOut  [3];
    logic         busy     [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        aes128_mix_columns #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (inValid[g]),
            .in_ready_o  (inReady[g]),
            .data_i      (dataIn[g]),
            .inv_i       (invIn[g]),
            .bypass_i    (bypassIn[g]),
            .out_valid_o (outValid[g]),
            .out_ready_i (outReady[g]),
            .data_o      (dataOut[g]),
            .busy_o      (busy[g])
        );
    end

    // Reference: shift-and-add GF(2^8) multiply and explicit circulant matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] modelState(input logic [127:0] s, input logic inv);
        logic [7:0] coef [4];
        logic [127:0] r = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(s[(c*4+j)*8 +: 8], coef[(j - row + 4) % 4]);
                r[(c*4+row)*8 +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Handshake one state through instance i; lat counts cycles from accept to first out_valid_o.
    task automatic runTxn(input int i, input logic [127:0] d, input logic iv, input logic bp,
                          output logic [127:0] res, output int lat);
        int guard = 0;
        while (!inReady[i] && guard < 20) begin @(posedge clk); #1; guard++; end
        inValid[i] = 1'b1; dataIn[i] = d; invIn[i] = iv; bypassIn[i] = bp;
        @(posedge clk); #1;
        inValid[i] = 1'b0; dataIn[i] = rand128(); invIn[i] = 1'($urandom); bypassIn[i] = 1'($urandom);
        lat = 1;
        while (!outValid[i] && lat < 20) begin @(posedge clk); #1; lat++; end
        res = dataOut[i];
        outReady[i] = 1'b1;
        @(posedge clk); #1;
        outReady[i] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outValid[i] !== 1'b0 || busy[i] !== 1'b0 || dataOut[i] !== 128'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got valid=%b busy=%b data=%h, want 0 0 0",
                         i, outValid[i], busy[i], dataOut[i]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inReady[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b want 1", i, inReady[i]);
            end
        end
    endtask

    task automatic test_known_vector();
        logic [127:0] res;
        int lat;
        runTxn(0, {4{32'h455313db}}, 1'b0, 1'b0, res, lat);
        checks++;
        if (res !== {4{32'hbca14d8e}}) begin
            errors++; $display("FAIL known_vector: got %h want %h", res, {4{32'hbca14d8e}});
        end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL known_latency: got %0d want 5", lat); end
    endtask

    task automatic test_roundtrip_vectors();
        logic [127:0] src = {32'hd5d4d4d4, 32'hc6c6c6c6, 32'h01010101, 32'h5c220af2};
        logic [127:0] fwdExp = {32'hd6d7d5d5, 32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f};
        logic [127:0] res, back;
        int lat;
        runTxn(0, src, 1'b0, 1'b0, res, lat);
        checks++;
        if (res !== fwdExp) begin errors++; $display("FAIL vec_forward: got %h want %h", res, fwdExp); end
        runTxn(0, res, 1'b1, 1'b0, back, lat);
        checks++;
        if (back !== src) begin errors++; $display("FAIL vec_inverse: got %h want %h", back, src); end
    endtask

    task automatic test_random();
        logic [127:0] d, res;
        logic iv;
        int lat;
        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 6; n++) begin
                d = rand128(); iv = 1'($urandom);
                runTxn(i, d, iv, 1'b0, res, lat);
                checks++;
                if (res !== modelState(d, iv) || lat !== 4 / (1 << i) + 1) begin
                    errors++;
                    $display("FAIL random[%0d] inv=%b: got %h lat %0d want %h lat %0d",
                             i, iv, res, lat, modelState(d, iv), 4 / (1 << i) + 1);
                end
            end
    endtask

    task automatic test_bypass();
        logic [127:0] d, res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            d = rand128();
            runTxn(i, d, 1'($urandom), 1'b1, res, lat);
            checks++;
            if (res !== d || lat !== 1) begin
                errors++;
                $display("FAIL bypass[%0d]: got %h lat %0d want %h lat 1", i, res, lat, d);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d = rand128();
        logic [127:0] snap;
        int guard = 0;
        inValid[0] = 1'b1; dataIn[0] = d; invIn[0] = 1'b0; bypassIn[0] = 1'b0;
        @(posedge clk); #1;
        inValid[0] = 1'b0;
        while (!outValid[0] && guard < 20) begin @(posedge clk); #1; guard++; end
        snap = dataOut[0];
        checks++;
        if (snap !== modelState(d, 1'b0)) begin
            errors++; $display("FAIL bp_result: got %h want %h", snap, modelState(d, 1'b0));
        end
        for (int n = 0; n < 10; n++) begin
            inValid[0] = 1'b1; dataIn[0] = rand128(); invIn[0] = 1'b1; bypassIn[0] = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (dataOut[0] !== snap || inReady[0] !== 1'b0 || outValid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: data=%h ready=%b valid=%b want %h 0 1",
                         n, dataOut[0], inReady[0], outValid[0], snap);
            end
        end
        inValid[0] = 1'b0; outReady[0] = 1'b1;
        @(posedge clk); #1;
        outReady[0] = 1'b0;
        checks++;
        if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", outValid[0], inReady[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d = rand128();
        logic [127:0] res;
        int lat;
        int pulses = 0;
        inValid[0] = 1'b1; dataIn[0] = d; invIn[0] = 1'b0; bypassIn[0] = 1'b0;
        @(posedge clk); #1;
        inValid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outValid[0] !== 1'b0 || busy[0] !== 1'b0 || dataOut[0] !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b data=%h want 0 0 0", outValid[0], busy[0], dataOut[0]);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 8; n++) begin
            if (outValid[0]) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses want 0", pulses); end
        d = rand128();
        runTxn(0, d, 1'b1, 1'b0, res, lat);
        checks++;
        if (res !== modelState(d, 1'b1)) begin
            errors++; $display("FAIL mid_after: got %h want %h", res, modelState(d, 1'b1));
        end
    endtask

    task automatic test_back_to_back(input int i, input int expLat);
        logic [127:0] expQ [$];
        int accQ [$];
        int cyc = 0;
        int got = 0;
        int guard = 0;
        logic prevAcc = 1'b0;
        logic [127:0] expD;
        int accC;
        dataIn[i] = {4{32'h455313db}}; invIn[i] = 1'b0; bypassIn[i] = 1'b0;
        outReady[i] = 1'b1; inValid[i] = 1'b1;
        while (got < 4 && cyc < 60) begin
            if (outValid[i]) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("FAIL b2b[%0d]: unexpected result %h", i, dataOut[i]);
                end else begin
                    expD = expQ.pop_front(); accC = accQ.pop_front();
                    if (dataOut[i] !== expD || cyc - accC !== expLat) begin
                        errors++;
                        $display("FAIL b2b[%0d] #%0d: got %h lat %0d want %h lat %0d",
                                 i, got, dataOut[i], cyc - accC, expD, expLat);
                    end
                end
                got++;
            end
            if (prevAcc) begin dataIn[i] = rand128(); invIn[i] = 1'($urandom); prevAcc = 1'b0; end
            if (inReady[i]) begin
                expQ.push_back(modelState(dataIn[i], invIn[i]));
                accQ.push_back(cyc);
                prevAcc = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        inValid[i] = 1'b0;
        if (got < 4) begin
            checks++; errors++;
            $display("FAIL b2b_timeout[%0d]: got %0d results want 4", i, got);
        end
        while (busy[i] && guard < 10) begin @(posedge clk); #1; guard++; end
        outReady[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            inValid[i] = 1'b0; dataIn[i] = '0; invIn[i] = 1'b0;
            bypassIn[i] = 1'b0; outReady[i] = 1'b0;
        end
        test_reset();
        test_known_vector();
        test_roundtrip_vectors();
        test_random();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(1, 3);
        test_back_to_back(2, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_mix_columns.md
AES128_MIX_COLUMNS -- requirements
Module: aes128_mix_columns

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns transformed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid_i, input, 1: data_i/inv_i/bypass_i valid.
REQ-005 SHALL have port in_ready_o, output, 1: block can accept a state.
REQ-006 SHALL have port data_i, input, 128: AES state; byte (row r, col c) at bits [(c*4+r)*8 +: 8]; column c = bits [c*32 +: 32], row 0 in the low byte.
REQ-007 SHALL have port inv_i, input, 1: 1 selects InvMixColumns; sampled at accept.
REQ-008 SHALL have port bypass_i, input, 1: 1 = final round, state passed unchanged; sampled at accept.
REQ-009 SHALL have port out_valid_o, output, 1: data_o holds a completed result.
REQ-010 SHALL have port out_ready_i, input, 1: consumer accepts the result.
REQ-011 SHALL have port data_o, output, 128: result, same byte layout as data_i.
REQ-012 SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready_o = 1 only in IDLE; no input is accepted in BUSY or DONE.
REQ-015 SHALL accept a state when in_valid_i && in_ready_o. It latches data_i into the working register, latches inv_i and bypass_i, and clears the column counter.
REQ-016 SHALL go IDLE->DONE on accept with bypass_i=1, with the result equal to data_i; out_valid_o is high in the next cycle.
REQ-017 SHALL go IDLE->BUSY on accept with bypass_i=0.
REQ-018 In each BUSY cycle, SHALL replace columns k..k+COLS_PER_CYCLE-1 of the working register in place with their transformed values, then advance k by COLS_PER_CYCLE.
REQ-019 SHALL go BUSY->DONE on the cycle that processes column 3; for accept in cycle 0, out_valid_o is first high in cycle 4/COLS_PER_CYCLE + 1.
REQ-020 Forward transform SHALL be s'0=2a0^3a1^a2^a3, s'1=a0^2a1^3a2^a3, s'2=a0^a1^2a2^3a3, s'3=3a0^a1^a2^2a3, in GF(2^8) mod 0x11B.
REQ-021 Inverse transform SHALL use the same matrix form with coefficients 0e,0b,0d,09 (rows rotated likewise), built from xtime only, with no multipliers.
REQ-022 SHALL drive out_valid_o = 1 only in DONE.
REQ-023 SHALL hold data_o stable while out_valid_o && !out_ready_i.
REQ-024 SHALL go DONE->IDLE on out_ready_i=1; in_ready_o rises in the following cycle.
REQ-025 SHALL drive data_o directly from the working register; its value outside DONE is don't-care but deterministic.
REQ-026 SHALL ignore in_valid_i, inv_i, bypass_i and data_i changes in BUSY and DONE.
REQ-027 SHALL ignore out_ready_i outside DONE.

Reset
REQ-028 On rst_n low, SHALL asynchronously force FSM=IDLE, column counter=0, working register=0, inv/bypass flags=0.
REQ-029 During and after reset, outputs SHALL be in_ready_o=1 (after release), out_valid_o=0, busy_o=0, data_o=0.
REQ-030 Reset mid-operation (BUSY or DONE) SHALL abort the transaction, discard the pending result, and produce no out_valid_o pulse.

Structure
REQ-031 The shared package aes128_pkg SHALL hold: the 128-bit state typedef, the 32-bit column typedef, the FSM state enum, the xtime function, and constant AES_POLY=8'h1B.
REQ-032 Sub-module aes128_mix_column SHALL be combinational, with inputs (32-bit column, inv) and a 32-bit output; the block instantiates it COLS_PER_CYCLE times.

Verification
REQ-033 Forward, COLS_PER_CYCLE=1: all four columns = 32'h455313db -> all columns 32'hbca14d8e; out_valid_o first high 5 cycles after accept.
REQ-034 Column vectors f2 0a 22 5c -> 9f dc 58 9d; 01 01 01 01 -> unchanged; c6 c6 c6 c6 -> unchanged; d4 d4 d4 d5 -> d5 d5 d7 d6, with inv_i=0. Each vector is then fed back with inv_i=1 and must return the original.
REQ-035 bypass_i=1 with random data -> data_o == data_i; out_valid_o high 1 cycle after accept.
REQ-036 Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> data_o stable, in_ready_o=0. In the same test, drive in_valid_i with new data -> ignored.
REQ-037 Assert rst_n low in the 2nd BUSY cycle -> immediate out_valid_o=0, busy_o=0, data_o=0; after release, the next transaction is correct.
REQ-038 Repeat REQ-033 with COLS_PER_CYCLE=2 (latency 3) and COLS_PER_CYCLE=4 (latency 2), using back-to-back transactions with out_ready_i tied high.
